// File: rtl/regfile_pkg.sv
// Shared constants and bus-slicing helpers for the pipelined register file.
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int ZERO_REG       = 0;

    // Widest packed port bus and widest single field the helpers can carry.
    localparam int MAX_BUS_W   = 256;
    localparam int MAX_FIELD_W = 64;

    // Returns field k of width w from a packed bus; caller narrows to w bits.
    function automatic logic [MAX_FIELD_W-1:0] port_field(
        input logic [MAX_BUS_W-1:0] bus,
        input int                   k,
        input int                   w
    );
        return MAX_FIELD_W'(bus >> (k * w));
    endfunction

    function automatic logic [MAX_BUS_W-1:0] widen_bus(input logic [MAX_BUS_W-1:0] bus);
        return bus;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits tracking in-flight producers; a new issue beats a retiring write.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 issue_wre,
    input  logic [ADDR_W-1:0]    issue_reg,
    input  logic [2**ADDR_W-1:0] clr_mask,
    output logic [2**ADDR_W-1:0] busy,
    output logic                 any_busy
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] set_mask;

    always_comb begin
        set_mask = '0;
        if (issue_wre && (issue_reg != ADDR_W'(ZERO_REG))) begin
            set_mask[issue_reg] = 1'b1;
        end
        busy_next = (busy_reg & ~clr_mask) | set_mask;
        busy_next[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy     = busy_reg;
    assign any_busy = |busy_reg;

endmodule

// File: rtl/pipeline_regfile.sv
// Multi-port register file with write-port priority, optional same-cycle bypass and RAW scoreboard.
module pipeline_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int BYPASS = 1
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic [NUM_WR-1:0]        RegWre,
    input  logic [NUM_WR*ADDR_W-1:0] WriteReg,
    input  logic [NUM_WR*DATA_W-1:0] WriteData,
    input  logic [NUM_RD*ADDR_W-1:0] ReadReg,
    output logic [NUM_RD*DATA_W-1:0] ReadData,
    output logic [NUM_RD-1:0]        ReadBusy,
    input  logic                     IssueWre,
    input  logic [ADDR_W-1:0]        IssueReg,
    output logic                     AnyBusy
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0]   mem_reg [NUM_REGS];
    logic [NUM_WR-1:0]   wr_valid;
    logic [ADDR_W-1:0]   wr_addr [NUM_WR];
    logic [DATA_W-1:0]   wr_data [NUM_WR];
    logic [ADDR_W-1:0]   rd_addr [NUM_RD];
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] busy;

    genvar gi;

    // Writes during reset and writes to r0 never count, for storage, bypass or scoreboard.
    generate
        for (gi = 0; gi < NUM_WR; gi++) begin : g_wr
            assign wr_addr[gi]  = ADDR_W'(port_field(widen_bus(MAX_BUS_W'(WriteReg)), gi, ADDR_W));
            assign wr_data[gi]  = DATA_W'(port_field(widen_bus(MAX_BUS_W'(WriteData)), gi, DATA_W));
            assign wr_valid[gi] = RegWre[gi] && !Reset && (wr_addr[gi] != ADDR_W'(ZERO_REG));
        end
    endgenerate

    always_comb begin
        clr_mask = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_valid[k]) begin
                clr_mask[wr_addr[k]] = 1'b1;
            end
        end
    end

    // Ascending port order: the last non-blocking update, from the highest port, wins.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_valid[k]) begin
                    mem_reg[wr_addr[k]] <= wr_data[k];
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [DATA_W-1:0] rd_value;
            logic              hit;

            assign rd_addr[gi] = ADDR_W'(port_field(widen_bus(MAX_BUS_W'(ReadReg)), gi, ADDR_W));

            always_comb begin
                hit      = 1'b0;
                rd_value = (rd_addr[gi] == ADDR_W'(ZERO_REG)) ? '0 : mem_reg[rd_addr[gi]];
                if (BYPASS != 0) begin
                    for (int k = 0; k < NUM_WR; k++) begin
                        if (wr_valid[k] && (wr_addr[k] == rd_addr[gi])) begin
                            hit      = 1'b1;
                            rd_value = wr_data[k];
                        end
                    end
                end
            end

            assign ReadData[gi*DATA_W +: DATA_W] = rd_value;
            assign ReadBusy[gi] = busy[rd_addr[gi]] && !hit;
        end
    endgenerate

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk       (CLK),
        .srst      (Reset),
        .issue_wre (IssueWre),
        .issue_reg (IssueReg),
        .clr_mask  (clr_mask),
        .busy      (busy),
        .any_busy  (AnyBusy)
    );

endmodule
